// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - phase encodings and sizing shared by the phase sequencer
package phase_pkg;

    localparam int CNT_W    = 6;
    localparam int MIN_LOAD = 1;

    typedef enum logic [1:0] {
        PH_GREEN = 2'b00,
        PH_AMBER = 2'b01,
        PH_RED   = 2'b10,
        PH_EMERG = 2'b11
    } phase_t;

    // Normal cycle order; EMERG never appears here, it is entered and left explicitly.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_GREEN: next_phase = PH_AMBER;
            PH_AMBER: next_phase = PH_RED;
            default:  next_phase = PH_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/phase_down_counter.sv
// rtl/phase_down_counter.sv - loadable down-counter with tick enable and expire flag
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count clears to 0)
//   load        load count with max(load_val, FLOOR); wins over tick_en
//   load_val    requested duration in ticks
//   tick_en     decrement strobe
//   count       remaining ticks
//   expire      tick_en arriving while count==1 (count holds at 1)
module phase_down_counter #(
    parameter int W     = 6,
    parameter int FLOOR = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick_en,
    output logic [W-1:0] count,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (load_val < W'(FLOOR)) ? W'(FLOOR) : load_val;
        end else if (tick_en && (count_q > W'(1))) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry leaves the count at 1; the next phase's load replaces it.
    assign expire = tick_en && !load && (count_q == W'(1));
    assign count  = count_q;

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - intersection phase FSM with request latches and phase counter
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   tick        1-cycle strobe, one per second
//   ped_req     pedestrian request (level or pulse)
//   emerg       emergency override level
//   preset      duration from gen_preset for the current state/specific
//   pulse       1-cycle load strobe to gen_preset
//   state       current phase (GREEN=00 AMBER=01 RED=10 EMERG=11)
//   specific    latched pedestrian flag fed to gen_preset
//   count       remaining ticks in the current phase
//   phase_done  1-cycle strobe on every phase change
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int CNT_W    = phase_pkg::CNT_W,
    parameter int MIN_LOAD = phase_pkg::MIN_LOAD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             emerg,
    input  logic [CNT_W-1:0] preset,
    output logic             pulse,
    output logic [1:0]       state,
    output logic             specific,
    output logic [CNT_W-1:0] count,
    output logic             phase_done
);

    phase_t state_q, state_d;
    logic   spec_q, spec_d;
    logic   pend_q, pend_d;      // pedestrian request waiting for the next GREEN
    logic   pulse_q, pulse_d;
    logic   done_q, done_d;
    logic   lpend_q;             // first LOAD after reset still owed
    logic   enter, reload;
    logic   tick_en, expire;
    logic [CNT_W-1:0] count_w;

    // Ticks are dropped while a load is owed or in progress.
    assign tick_en = tick && !pulse_q && !lpend_q;

    phase_down_counter #(
        .W     (CNT_W),
        .FLOOR (MIN_LOAD)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pulse_q),
        .load_val (preset),
        .tick_en  (tick_en),
        .count    (count_w),
        .expire   (expire)
    );

    always_comb begin
        state_d = state_q;
        spec_d  = spec_q;
        pend_d  = pend_q;
        enter   = 1'b0;
        reload  = 1'b0;

        if (emerg && (state_q != PH_EMERG)) begin
            state_d = PH_EMERG;
            enter   = 1'b1;
        end else if (expire) begin
            if (state_q == PH_EMERG) begin
                if (emerg) begin
                    reload = 1'b1;
                end else begin
                    state_d = PH_RED;
                    enter   = 1'b1;
                end
            end else begin
                state_d = next_phase(state_q);
                enter   = 1'b1;
            end
        end

        // GREEN/AMBER requests extend this cycle's RED; later ones wait for the next GREEN.
        if (ped_req) begin
            if ((state_q == PH_GREEN) || (state_q == PH_AMBER)) begin
                spec_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        if (enter && (state_q == PH_RED)) begin
            if (state_d == PH_GREEN) begin
                spec_d = pend_d;
                pend_d = 1'b0;
            end else begin
                spec_d = 1'b0;
            end
        end

        // Leaving EMERG forces a plain RED; an unserved flag carries to the next GREEN.
        if (enter && (state_q == PH_EMERG)) begin
            pend_d = pend_d || spec_q;
            spec_d = 1'b0;
        end

        done_d  = enter;
        pulse_d = enter || reload || lpend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PH_RED;
            spec_q  <= 1'b0;
            pend_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            lpend_q <= 1'b1;
        end else begin
            state_q <= state_d;
            spec_q  <= spec_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            lpend_q <= 1'b0;
        end
    end

    assign pulse      = pulse_q;
    assign state      = state_q;
    assign specific   = spec_q;
    assign count      = count_w;
    assign phase_done = done_q;

    a_count_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (lpend_q || pulse_q || (count_w != '0)));

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
module tb_phase_sequencer;

    localparam int GREEN = 0, AMBER = 1, RED = 2, EMERG = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [5:0] preset;
    logic       pulse;
    logic [1:0] state;
    logic       specific;
    logic [5:0] count;
    logic       phase_done;

    bit zero_mode = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int m_state, m_count;
    bit m_pulse, m_done, m_spec, m_pend, m_lpend;

    always #5 clk = ~clk;

    // gen_preset environment model
    function automatic int gp(input int s, input bit sp);
        case (s)
            GREEN:   return sp ? 20 : 30;
            AMBER:   return 5;
            RED:     return sp ? 22 : 15;
            default: return 4;
        endcase
    endfunction

    assign preset = zero_mode ? 6'd0 : 6'(gp(int'(state), specific));

    phase_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .ped_req    (ped_req),
        .emerg      (emerg),
        .preset     (preset),
        .pulse      (pulse),
        .state      (state),
        .specific   (specific),
        .count      (count),
        .phase_done (phase_done)
    );

    typedef struct {
        bit t, p, e;
        int st, cnt;
        bit pl, dn, sp;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("state", int'(state), m_state);
        check("count", int'(count), m_count);
        check("pulse", int'(pulse), int'(m_pulse));
        check("phase_done", int'(phase_done), int'(m_done));
        check("specific", int'(specific), int'(m_spec));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, int'(state), RED);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_pulse"}, int'(pulse), 0);
        check({tag, "_done"}, int'(phase_done), 0);
        check({tag, "_spec"}, int'(specific), 0);
    endtask

    task automatic model_reset();
        m_state = RED; m_count = 0; m_pulse = 0; m_done = 0;
        m_spec = 0; m_pend = 0; m_lpend = 1;
    endtask

    // Behaviour of one clock edge, stated as phase rules.
    task automatic model_edge(input bit t, input bit p, input bit e);
        int  ns, ld;
        bit  tick_ok, expired, enter, reload, nspec, npend;
        ld      = zero_mode ? 0 : gp(m_state, m_spec);
        tick_ok = t && !m_pulse && !m_lpend;
        expired = tick_ok && (m_count == 1);
        ns = m_state; enter = 0; reload = 0;
        if (e && m_state != EMERG) begin
            ns = EMERG; enter = 1;
        end else if (expired) begin
            if (m_state == EMERG) begin
                if (e) reload = 1;
                else begin ns = RED; enter = 1; end
            end else begin
                ns = (m_state + 1) % 3; enter = 1;
            end
        end
        nspec = m_spec; npend = m_pend;
        if (p) begin
            if (m_state == GREEN || m_state == AMBER) nspec = 1;
            else npend = 1;
        end
        if (enter && m_state == RED) begin
            nspec = (ns == GREEN) ? npend : 1'b0;
            if (ns == GREEN) npend = 0;
        end
        if (enter && m_state == EMERG) begin
            npend = npend | m_spec;
            nspec = 0;
        end
        if (m_pulse) m_count = (ld < 1) ? 1 : ld;
        else if (tick_ok && !expired) m_count = m_count - 1;
        m_pulse = enter | reload | m_lpend;
        m_done  = enter;
        m_lpend = 0;
        m_state = ns; m_spec = nspec; m_pend = npend;
    endtask

    task automatic step(input bit t, input bit p, input bit e, input bit cmp);
        tick = t; ped_req = p; emerg = e;
        @(posedge clk);
        model_edge(t, p, e);
        @(negedge clk);
        cyc++;
        if (cmp) check_model();
    endtask

    task automatic tstep(input bit p, input bit e);
        step(cyc % 4 == 0, p, e, 1'b1);
    endtask

    task automatic wait_for(input int s, input int c, input bit e, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (m_state == s && m_count == c && !m_pulse && !m_lpend) hit = 1;
            else tstep(1'b0, e);
        end
        if (!hit) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_%s: got no phase %0d count %0d required within 2000 clk", name, s, c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; tick = 0; ped_req = 0; emerg = 0;
        @(negedge clk);
        check_reset_vals("reset");
        model_reset();
        rst_n = 1;
    endtask

    initial begin
        vec_t vt[11];
        bit em;

        vt[0]  = '{1,0,0, RED,   0, 1,0,0};
        vt[1]  = '{1,0,0, RED,  15, 0,0,0};
        vt[2]  = '{1,0,0, RED,  14, 0,0,0};
        vt[3]  = '{0,1,0, RED,  14, 0,0,0};
        vt[4]  = '{0,0,1, EMERG,14, 1,1,0};
        vt[5]  = '{1,0,0, EMERG, 4, 0,0,0};
        vt[6]  = '{1,0,0, EMERG, 3, 0,0,0};
        vt[7]  = '{1,0,0, EMERG, 2, 0,0,0};
        vt[8]  = '{1,0,0, EMERG, 1, 0,0,0};
        vt[9]  = '{1,0,0, RED,   1, 1,1,0};
        vt[10] = '{1,0,0, RED,  15, 0,0,0};

        model_reset();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(vt[i].t, vt[i].p, vt[i].e, 1'b0);
            check($sformatf("vec%0d_state", i), int'(state), vt[i].st);
            check($sformatf("vec%0d_count", i), int'(count), vt[i].cnt);
            check($sformatf("vec%0d_pulse", i), int'(pulse), int'(vt[i].pl));
            check($sformatf("vec%0d_done", i), int'(phase_done), int'(vt[i].dn));
            check($sformatf("vec%0d_spec", i), int'(specific), int'(vt[i].sp));
        end

        // Full loop without requests
        do_reset();
        wait_for(RED, 15, 0, "first_red");
        check("first_red_load", int'(count), 15);
        wait_for(GREEN, 30, 0, "green");
        check("green_load", int'(count), 30);
        wait_for(AMBER, 5, 0, "amber");
        check("amber_load", int'(count), 5);
        wait_for(RED, 15, 0, "red");
        check("red_load", int'(count), 15);
        wait_for(GREEN, 30, 0, "green2");

        // Pedestrian pulse mid-GREEN
        wait_for(GREEN, 15, 0, "green_mid");
        tstep(1'b1, 1'b0);
        wait_for(AMBER, 5, 0, "amber_ped");
        check("spec_in_amber", int'(specific), 1);
        wait_for(RED, 22, 0, "red_ped");
        check("red_ped_load", int'(count), 22);
        wait_for(GREEN, 30, 0, "green_after_ped");
        check("spec_after_red", int'(specific), 0);

        // Pedestrian pulse during RED
        wait_for(RED, 15, 0, "red_plain");
        wait_for(RED, 10, 0, "red_mid");
        tstep(1'b1, 1'b0);
        wait_for(RED, 1, 0, "red_end");
        wait_for(GREEN, 20, 0, "green_spec");
        check("spec_green_entry", int'(specific), 1);

        // Emergency at AMBER count 3, held past one expiry
        wait_for(AMBER, 3, 0, "amber3");
        tstep(1'b0, 1'b1);
        check("emerg_state", int'(state), EMERG);
        check("emerg_pulse", int'(pulse), 1);
        check("emerg_done", int'(phase_done), 1);
        for (int i = 0; i < 30; i++) tstep(1'b0, 1'b1);
        wait_for(RED, 15, 0, "red_after_emerg");
        check("spec_after_emerg", int'(specific), 0);

        // preset=0 loads the floor
        zero_mode = 1;
        tstep(1'b0, 1'b1);
        tstep(1'b0, 1'b1);
        check("min_load", int'(count), 1);
        zero_mode = 0;
        wait_for(RED, 15, 0, "red_after_zero");

        // Randomized run against the model
        em = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) em = ~em;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, em, 1'b1);
        end

        // Asynchronous reset mid-GREEN
        wait_for(GREEN, 10, 0, "green_async");
        #2 rst_n = 0;
        #1 check_reset_vals("async");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) tstep(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
